mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single unified memory between two bus masters: master_1 is CPU instruction fetch, master_2 is CPU data access.
- Sits between the CPU bus ports and the memory slave port inside Top.
- Round-robin arbitration; one outstanding transaction at a time.
- A watchdog returns an error response if the memory never answers.

Parameters:
- ADDR_W, 16, address width (byte address, matches 64 KiB memory map).
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum cycles from slave request issue to slave response before the error response; range 1..65535.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- master_1_req_valid  in  1  master_1 request pending.
- master_1_req_ready  out  1  master_1 request accepted this cycle.
- master_1_addr  in  ADDR_W  master_1 address.
- master_1_write  in  1  1=write, 0=read.
- master_1_wdata  in  DATA_W  master_1 write data.
- master_1_wstrb  in  DATA_W/8  master_1 byte enables.
- master_1_resp_valid  out  1  one-cycle response pulse to master_1.
- master_1_resp_err  out  1  response is a timeout error.
- master_1_rdata  out  DATA_W  read data to master_1.
- master_2_* : same nine signals as master_1, for master_2.
- slave_req_valid  out  1  request to memory.
- slave_req_ready  in  1  memory accepts request.
- slave_addr  out  ADDR_W  latched address.
- slave_write  out  1  latched write flag.
- slave_wdata  out  DATA_W  latched write data.
- slave_wstrb  out  DATA_W/8  latched byte enables.
- slave_resp_valid  in  1  memory response (read data or write ack).
- slave_rdata  in  DATA_W  memory read data.
- busy  out  1  1 while state is not IDLE.

Behaviour:
Reset:
- rst=1 at a clock edge forces state=IDLE, owner=master_1, last_grant=master_2, timer=0.
- All valid, ready and err outputs are 0; all data/address outputs are 0.
- Reset mid-transaction drops the transaction; no response is delivered to either master.

States:
- IDLE:
  - Grant is combinational from the valids.
  - Only one valid → that master wins. Both valid → the master not equal to last_grant wins.
  - Winner's req_ready=1 in the same cycle; the other master's req_ready=0.
  - At the edge: latch addr/write/wdata/wstrb, set owner and last_grant=winner, timer=0, go to ADDR.
  - req_ready is never asserted outside IDLE.
- ADDR:
  - slave_req_valid=1 with the latched fields held stable.
  - slave_req_ready=1 → go to DATA.
  - Timer increments each cycle in ADDR and DATA.
- DATA:
  - Wait for slave_resp_valid.
  - On slave_resp_valid: register owner's rdata=slave_rdata, resp_err=0, resp_valid=1 for exactly the next cycle; go to IDLE.
  - Writes also wait for slave_resp_valid (used as ack); rdata content is then don't-care.
- Timeout: in ADDR or DATA, if timer==TIMEOUT-1 and the state's exit condition is not met → owner resp_valid=1, resp_err=1, rdata=0 next cycle; go to IDLE.
- Slave response arrives on the same edge as timeout: the response wins, err=0.

Other rules:
- Non-owner resp_valid is always 0. slave_resp_valid outside DATA is ignored.
- resp_valid is visible in the first IDLE cycle, and a new grant may occur in that same cycle (back-to-back throughput: 1 grant per 3 cycles with a zero-wait slave).
- Masters keep req_valid and fields stable until req_ready. The arbiter does not check this.
- Timer width is clog2(TIMEOUT+1) bits, saturating; it never wraps.

Decomposition:
- Shared package bus_pkg holds:
  - state enum {IDLE, ADDR, DATA};
  - master id constants MASTER_1=0, MASTER_2=1;
  - default ADDR_W/DATA_W/TIMEOUT values.
- Optional sub-module rr_arbiter2: 2-input round-robin grant from (valid_1, valid_2, last_grant) → grant one-hot.
- FSM, latches, timer and response registers stay in mem_bus_arbiter.

Test Plan:
- Reset: assert rst for 2 cycles mid-DATA → next cycle all outputs 0, busy=0; slave_resp_valid then has no master response.
- Single read: master_1 read addr 0x0004, zero-wait slave returns 0xDEADBEEF → master_1_req_ready at cycle 0, slave_req_valid at cycle 1, master_1_resp_valid with rdata 0xDEADBEEF, err=0 at cycle 3.
- Contention fairness: both masters request continuously, 4 transactions each → grant order m1,m2,m1,m2,... and exactly 8 responses, each to the correct owner.
- Write with strobes: master_2 write addr 0x8000, wdata 0x11223344, wstrb 0b0011 → slave sees identical fields held over 3 slave_req_ready-low cycles; master_2_resp_valid after ack.
- Timeout: TIMEOUT=8, slave never responds → master_1_resp_err=1, rdata=0, exactly 8 cycles after entering ADDR; a late slave_resp_valid is ignored.
- Race: slave_resp_valid on the timeout cycle → resp_err=0 and rdata equals slave_rdata.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   state_e            : arbiter FSM states
//   MASTER_1/MASTER_2  : master identifiers (used for owner / last_grant)
//   *_DEF              : default geometry and watchdog limit
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic MASTER_1 = 1'b0;
    localparam logic MASTER_2 = 1'b1;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant (combinational).
//   valid_1_i, valid_2_i : request lines of master_1 / master_2
//   last_grant_i         : master id that won the previous arbitration
//   grant_c_o[1:0]       : one-hot grant, bit0 = master_1, bit1 = master_2
module rr_arbiter2
    import bus_pkg::*;
(
    input  logic       valid_1_i,
    input  logic       valid_2_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_c_o
);

    // On contention the master that did not win last time is served.
    always_comb begin
        grant_c_o = 2'b00;
        if (valid_1_i && valid_2_i) begin
            grant_c_o = (last_grant_i == MASTER_1) ? 2'b10 : 2'b01;
        end else if (valid_1_i) begin
            grant_c_o = 2'b01;
        end else if (valid_2_i) begin
            grant_c_o = 2'b10;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory slave port between CPU instruction fetch (master_1)
// and CPU data access (master_2). Round-robin, one transaction in flight,
// watchdog error response when the memory does not answer within TIMEOUT.
//   clk, rst (sync, active-high)
//   master_{1,2}_req_* : request handshake + address/write/wdata/wstrb
//   master_{1,2}_resp_*: one-cycle response pulse with err flag and rdata
//   slave_req_* / slave_resp_* : memory side, fields latched at grant
//   busy               : arbiter is not IDLE
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                master_1_req_valid,
    output logic                master_1_req_ready,
    input  logic [ADDR_W-1:0]   master_1_addr,
    input  logic                master_1_write,
    input  logic [DATA_W-1:0]   master_1_wdata,
    input  logic [DATA_W/8-1:0] master_1_wstrb,
    output logic                master_1_resp_valid,
    output logic                master_1_resp_err,
    output logic [DATA_W-1:0]   master_1_rdata,

    input  logic                master_2_req_valid,
    output logic                master_2_req_ready,
    input  logic [ADDR_W-1:0]   master_2_addr,
    input  logic                master_2_write,
    input  logic [DATA_W-1:0]   master_2_wdata,
    input  logic [DATA_W/8-1:0] master_2_wstrb,
    output logic                master_2_resp_valid,
    output logic                master_2_resp_err,
    output logic [DATA_W-1:0]   master_2_rdata,

    output logic                slave_req_valid,
    input  logic                slave_req_ready,
    output logic [ADDR_W-1:0]   slave_addr,
    output logic                slave_write,
    output logic [DATA_W-1:0]   slave_wdata,
    output logic [DATA_W/8-1:0] slave_wstrb,
    input  logic                slave_resp_valid,
    input  logic [DATA_W-1:0]   slave_rdata,

    output logic                busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    logic                m1_valid_q, m1_valid_d;
    logic                m1_err_q, m1_err_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                m2_valid_q, m2_valid_d;
    logic                m2_err_q, m2_err_d;
    logic [DATA_W-1:0]   m2_rdata_q, m2_rdata_d;

    logic [1:0]          grant_c;
    logic [TMR_W-1:0]    timer_inc_c;
    logic                timeout_c;
    logic                fire_c;
    logic                fire_err_c;
    logic [DATA_W-1:0]   fire_data_c;

    rr_arbiter2 u_rr (
        .valid_1_i    (master_1_req_valid),
        .valid_2_i    (master_2_req_valid),
        .last_grant_i (last_q),
        .grant_c_o    (grant_c)
    );

    // Saturating watchdog so the counter can never wrap back into range.
    assign timer_inc_c = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    assign timeout_c   = (timer_q == TMR_LAST);

    // Next-state, latch and response logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        timer_d     = timer_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        m1_valid_d  = 1'b0;
        m1_err_d    = 1'b0;
        m1_rdata_d  = m1_rdata_q;
        m2_valid_d  = 1'b0;
        m2_err_d    = 1'b0;
        m2_rdata_d  = m2_rdata_q;
        fire_c      = 1'b0;
        fire_err_c  = 1'b0;
        fire_data_c = '0;

        case (state_q)
            IDLE: begin
                if (grant_c[0]) begin
                    owner_d = MASTER_1;
                    last_d  = MASTER_1;
                    addr_d  = master_1_addr;
                    write_d = master_1_write;
                    wdata_d = master_1_wdata;
                    wstrb_d = master_1_wstrb;
                    timer_d = '0;
                    state_d = ADDR;
                end else if (grant_c[1]) begin
                    owner_d = MASTER_2;
                    last_d  = MASTER_2;
                    addr_d  = master_2_addr;
                    write_d = master_2_write;
                    wdata_d = master_2_wdata;
                    wstrb_d = master_2_wstrb;
                    timer_d = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                timer_d = timer_inc_c;
                if (slave_req_ready) begin
                    state_d = DATA;
                end else if (timeout_c) begin
                    fire_c     = 1'b1;
                    fire_err_c = 1'b1;
                end
            end
            DATA: begin
                timer_d = timer_inc_c;
                // A response on the timeout cycle takes priority over the error.
                if (slave_resp_valid) begin
                    fire_c      = 1'b1;
                    fire_data_c = slave_rdata;
                end else if (timeout_c) begin
                    fire_c     = 1'b1;
                    fire_err_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire_c) begin
            state_d = IDLE;
            if (owner_q == MASTER_1) begin
                m1_valid_d = 1'b1;
                m1_err_d   = fire_err_c;
                m1_rdata_d = fire_data_c;
            end else begin
                m2_valid_d = 1'b1;
                m2_err_d   = fire_err_c;
                m2_rdata_d = fire_data_c;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= MASTER_1;
            last_q     <= MASTER_2;
            timer_q    <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            m1_valid_q <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= '0;
            m2_valid_q <= 1'b0;
            m2_err_q   <= 1'b0;
            m2_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            m1_valid_q <= m1_valid_d;
            m1_err_q   <= m1_err_d;
            m1_rdata_q <= m1_rdata_d;
            m2_valid_q <= m2_valid_d;
            m2_err_q   <= m2_err_d;
            m2_rdata_q <= m2_rdata_d;
        end
    end

    // Grant is visible in the same IDLE cycle it is decided.
    assign master_1_req_ready  = (state_q == IDLE) && grant_c[0];
    assign master_2_req_ready  = (state_q == IDLE) && grant_c[1];

    assign master_1_resp_valid = m1_valid_q;
    assign master_1_resp_err   = m1_err_q;
    assign master_1_rdata      = m1_rdata_q;
    assign master_2_resp_valid = m2_valid_q;
    assign master_2_resp_err   = m2_err_q;
    assign master_2_rdata      = m2_rdata_q;

    assign slave_req_valid     = (state_q == ADDR);
    assign slave_addr          = addr_q;
    assign slave_write         = write_q;
    assign slave_wdata         = wdata_q;
    assign slave_wstrb         = wstrb_q;

    assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT = 8).
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              m1_req_valid, m1_req_ready, m1_write, m1_resp_valid, m1_resp_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [3:0]        m1_wstrb;
    logic              m2_req_valid, m2_req_ready, m2_write, m2_resp_valid, m2_resp_err;
    logic [ADDR_W-1:0] m2_addr;
    logic [DATA_W-1:0] m2_wdata, m2_rdata;
    logic [3:0]        m2_wstrb;
    logic              s_req_valid, s_req_ready, s_write, s_resp_valid, busy;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata, s_rdata, rdata_drv;
    logic [3:0]        s_wstrb;
    logic              echo;

    int checks = 0;
    int errors = 0;

    // Echo mode lets the contention test identify which request was served.
    assign s_rdata = echo ? {16'hC0DE, s_addr} : rdata_drv;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .master_1_req_valid(m1_req_valid), .master_1_req_ready(m1_req_ready),
        .master_1_addr(m1_addr), .master_1_write(m1_write),
        .master_1_wdata(m1_wdata), .master_1_wstrb(m1_wstrb),
        .master_1_resp_valid(m1_resp_valid), .master_1_resp_err(m1_resp_err),
        .master_1_rdata(m1_rdata),
        .master_2_req_valid(m2_req_valid), .master_2_req_ready(m2_req_ready),
        .master_2_addr(m2_addr), .master_2_write(m2_write),
        .master_2_wdata(m2_wdata), .master_2_wstrb(m2_wstrb),
        .master_2_resp_valid(m2_resp_valid), .master_2_resp_err(m2_resp_err),
        .master_2_rdata(m2_rdata),
        .slave_req_valid(s_req_valid), .slave_req_ready(s_req_ready),
        .slave_addr(s_addr), .slave_write(s_write), .slave_wdata(s_wdata),
        .slave_wstrb(s_wstrb), .slave_resp_valid(s_resp_valid),
        .slave_rdata(s_rdata), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({busy, s_req_valid, m1_req_ready, m2_req_ready, m1_resp_valid, m1_resp_err,
             m2_resp_valid, m2_resp_err, s_write} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%0b sreqv=%0b rdy=%0b%0b rv=%0b%0b err=%0b%0b wr=%0b exp all 0",
                     busy, s_req_valid, m1_req_ready, m2_req_ready, m1_resp_valid, m2_resp_valid,
                     m1_resp_err, m2_resp_err, s_write);
        end
        checks++;
        if ({s_addr, s_wdata, s_wstrb, m1_rdata, m2_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%h rd1=%h rd2=%h exp 0",
                     s_addr, s_wdata, s_wstrb, m1_rdata, m2_rdata);
        end
    endtask

    task automatic test_single_read();
        s_req_ready = 1'b1;
        m1_req_valid = 1'b1; m1_addr = 16'h0004; m1_write = 1'b0;
        #1;
        checks++;
        if (m1_req_ready !== 1'b1 || m2_req_ready !== 1'b0 || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_grant: got rdy1=%0b rdy2=%0b sreqv=%0b exp 1 0 0", m1_req_ready, m2_req_ready, s_req_valid);
        end
        step();
        m1_req_valid = 1'b0;
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 16'h0004 || s_write !== 1'b0 || busy !== 1'b1 || m1_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr: got sreqv=%0b addr=%h wr=%0b busy=%0b rdy1=%0b exp 1 0004 0 1 0",
                     s_req_valid, s_addr, s_write, busy, m1_req_ready);
        end
        step();
        s_resp_valid = 1'b1; rdata_drv = 32'hDEADBEEF;
        checks++;
        if (s_req_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got sreqv=%0b rv1=%0b exp 0 0", s_req_valid, m1_resp_valid);
        end
        step();
        s_resp_valid = 1'b0;
        checks++;
        if (m1_resp_valid !== 1'b1 || m1_resp_err !== 1'b0 || m1_rdata !== 32'hDEADBEEF ||
            m2_resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: got rv1=%0b err=%0b rdata=%h rv2=%0b busy=%0b exp 1 0 deadbeef 0 0",
                     m1_resp_valid, m1_resp_err, m1_rdata, m2_resp_valid, busy);
        end
        step();
        checks++;
        if (m1_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse: got rv1=%0b exp 0", m1_resp_valid);
        end
        s_req_ready = 1'b0;
    endtask

    task automatic test_write_strobes();
        s_req_ready = 1'b0;
        m2_req_valid = 1'b1; m2_addr = 16'h8000; m2_write = 1'b1;
        m2_wdata = 32'h11223344; m2_wstrb = 4'b0011;
        #1;
        checks++;
        if (m2_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_grant: got rdy2=%0b rdy1=%0b exp 1 0", m2_req_ready, m1_req_ready);
        end
        step();
        // Scramble master inputs: the slave must keep seeing the latched copy.
        m2_req_valid = 1'b0; m2_addr = 16'hFFFF; m2_write = 1'b0; m2_wdata = '0; m2_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) s_req_ready = 1'b1;
            #1;
            checks++;
            if (s_req_valid !== 1'b1 || s_addr !== 16'h8000 || s_write !== 1'b1 ||
                s_wdata !== 32'h11223344 || s_wstrb !== 4'b0011) begin
                errors++;
                $display("FAIL wr_hold[%0d]: got v=%0b a=%h w=%0b d=%h s=%b exp 1 8000 1 11223344 0011",
                         i, s_req_valid, s_addr, s_write, s_wdata, s_wstrb);
            end
            step();
        end
        s_req_ready = 1'b0; s_resp_valid = 1'b1; rdata_drv = 32'h0;
        step();
        s_resp_valid = 1'b0;
        checks++;
        if (m2_resp_valid !== 1'b1 || m2_resp_err !== 1'b0 || m1_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack: got rv2=%0b err2=%0b rv1=%0b exp 1 0 0", m2_resp_valid, m2_resp_err, m1_resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int resp_count;
        logic exp2;
        resp_count = 0;
        apply_reset();
        echo = 1'b1; s_req_ready = 1'b1; s_resp_valid = 1'b1;
        m1_addr = 16'h0100; m1_write = 1'b0; m2_addr = 16'h0200; m2_write = 1'b0;
        m1_req_valid = 1'b1; m2_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp2 = (k % 2) == 1;
            #1;
            checks++;
            if (m1_req_ready !== !exp2 || m2_req_ready !== exp2) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got rdy1=%0b rdy2=%0b exp %0b %0b", k, m1_req_ready, m2_req_ready, !exp2, exp2);
            end
            step();
            step();
            step();
            if (k == 7) begin
                m1_req_valid = 1'b0; m2_req_valid = 1'b0;
            end
            checks++;
            if (!exp2 && m1_resp_valid === 1'b1 && m2_resp_valid === 1'b0 && m1_rdata === 32'hC0DE0100) begin
                resp_count++;
            end else if (exp2 && m2_resp_valid === 1'b1 && m1_resp_valid === 1'b0 && m2_rdata === 32'hC0DE0200) begin
                resp_count++;
            end else begin
                errors++;
                $display("FAIL rr_resp[%0d]: got rv1=%0b rv2=%0b rd1=%h rd2=%h exp owner m%0d", k,
                         m1_resp_valid, m2_resp_valid, m1_rdata, m2_rdata, exp2 ? 2 : 1);
            end
        end
        step();
        checks++;
        if (resp_count != 8 || busy !== 1'b0 || m1_resp_valid !== 1'b0 || m2_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_count: got %0d responses busy=%0b exp 8 idle", resp_count, busy);
        end
        echo = 1'b0; s_req_ready = 1'b0; s_resp_valid = 1'b0;
    endtask

    task automatic test_timeout();
        s_req_ready = 1'b0; s_resp_valid = 1'b0;
        m1_req_valid = 1'b1; m1_addr = 16'h0010; m1_write = 1'b0;
        step();
        m1_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (s_req_valid !== 1'b1 || m1_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL to_wait[%0d]: got sreqv=%0b rv1=%0b exp 1 0", c, s_req_valid, m1_resp_valid);
            end
            step();
        end
        checks++;
        if (m1_resp_valid !== 1'b1 || m1_resp_err !== 1'b1 || m1_rdata !== 32'h0 ||
            busy !== 1'b0 || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_err: got rv1=%0b err=%0b rdata=%h busy=%0b sreqv=%0b exp 1 1 0 0 0",
                     m1_resp_valid, m1_resp_err, m1_rdata, busy, s_req_valid);
        end
        s_resp_valid = 1'b1; rdata_drv = 32'h5555AAAA;
        step();
        step();
        s_resp_valid = 1'b0;
        checks++;
        if (m1_resp_valid !== 1'b0 || m2_resp_valid !== 1'b0 || m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_late: got rv1=%0b rv2=%0b rd1=%h exp 0 0 0", m1_resp_valid, m2_resp_valid, m1_rdata);
        end
    endtask

    task automatic test_race();
        m2_req_valid = 1'b1; m2_addr = 16'h0020; m2_write = 1'b0;
        s_req_ready = 1'b1;
        step();
        m2_req_valid = 1'b0;
        step();
        s_req_ready = 1'b0;
        for (int c = 2; c < 8; c++) begin
            checks++;
            if (m2_resp_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL race_wait[%0d]: got rv2=%0b busy=%0b exp 0 1", c, m2_resp_valid, busy);
            end
            step();
        end
        s_resp_valid = 1'b1; rdata_drv = 32'hCAFEF00D;
        step();
        s_resp_valid = 1'b0;
        checks++;
        if (m2_resp_valid !== 1'b1 || m2_resp_err !== 1'b0 || m2_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL race_resp: got rv2=%0b err=%0b rdata=%h exp 1 0 cafef00d", m2_resp_valid, m2_resp_err, m2_rdata);
        end
    endtask

    task automatic test_reset_mid();
        m1_req_valid = 1'b1; m1_addr = 16'h0030; m1_write = 1'b1; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
        s_req_ready = 1'b1;
        step();
        m1_req_valid = 1'b0;
        step();
        s_req_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_data: got busy=%0b sreqv=%0b exp 1 0", busy, s_req_valid);
        end
        apply_reset();
        checks++;
        if ({busy, s_req_valid, m1_req_ready, m2_req_ready, m1_resp_valid, m2_resp_valid, s_write} !== 7'b0 ||
            {s_addr, s_wdata, s_wstrb, m1_rdata, m2_rdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%0b sreqv=%0b a=%h d=%h s=%h rd1=%h rd2=%h exp all 0",
                     busy, s_req_valid, s_addr, s_wdata, s_wstrb, m1_rdata, m2_rdata);
        end
        s_resp_valid = 1'b1; rdata_drv = 32'h12345678;
        step();
        s_resp_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (m1_resp_valid !== 1'b0 || m2_resp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_noresp[%0d]: got rv1=%0b rv2=%0b busy=%0b exp 0 0 0", c, m1_resp_valid, m2_resp_valid, busy);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1; echo = 1'b0;
        m1_req_valid = 1'b0; m1_addr = '0; m1_write = 1'b0; m1_wdata = '0; m1_wstrb = '0;
        m2_req_valid = 1'b0; m2_addr = '0; m2_write = 1'b0; m2_wdata = '0; m2_wstrb = '0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; rdata_drv = '0;
        test_reset();
        test_single_read();
        test_write_strobes();
        test_back_to_back();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
